// File: rtl/fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO with a registered occupancy count,
// almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow flags.
module fifo_sync_fwft #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = 12,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      clr_err,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW:0] One    = CW'(1);
  localparam logic [AW:0] DepthC = CW'(DEPTH);
  localparam logic [AW:0] AfLvl  = CW'(AF_THRESH);
  localparam logic [AW:0] AeLvl  = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wrPtrQ, wrPtrD;
  logic [AW:0] rdPtrQ, rdPtrD;
  logic [AW:0] countQ, countD;
  logic        overflowQ, overflowD;
  logic        underflowQ, underflowD;
  logic        wrAcc, rdAcc;

  // Flags decode purely from the registered count.
  assign empty        = (countQ == '0);
  assign full         = (countQ == DepthC);
  assign almost_empty = (countQ <= AeLvl);
  assign almost_full  = (countQ >= AfLvl);
  assign count        = countQ;
  assign overflow     = overflowQ;
  assign underflow    = underflowQ;

  assign rdAcc = rd_en & ~empty;
  assign wrAcc = wr_en & (~full | rdAcc);

  always_comb begin
    wrPtrD     = wrPtrQ;
    rdPtrD     = rdPtrQ;
    countD     = countQ;
    overflowD  = overflowQ & ~clr_err;
    underflowD = underflowQ & ~clr_err;
    if (flush) begin
      wrPtrD = '0;
      rdPtrD = '0;
      countD = '0;
    end else begin
      if (wrAcc) wrPtrD = wrPtrQ + One;
      if (rdAcc) rdPtrD = rdPtrQ + One;
      unique case ({wrAcc, rdAcc})
        2'b10:   countD = countQ + One;
        2'b01:   countD = countQ - One;
        default: countD = countQ;
      endcase
      // A new error event wins over a coincident clear.
      if (wr_en && !wrAcc) overflowD = 1'b1;
      if (rd_en && !rdAcc) underflowD = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtrQ     <= '0;
      rdPtrQ     <= '0;
      countQ     <= '0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      wrPtrQ     <= wrPtrD;
      rdPtrQ     <= rdPtrD;
      countQ     <= countD;
      overflowQ  <= overflowD;
      underflowQ <= underflowD;
    end
  end

  // Storage is not reset; only the pointer low bits address it.
  always_ff @(posedge clock) begin
    if (wrAcc && !flush) mem[wrPtrQ[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rdPtrQ[AW-1:0]];

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed self-checking bench for fifo_sync_fwft at default parameters (8 x 16, AF 12, AE 2).
module tb_fifo_sync_fwft;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       flush, clr_err, wr_en, rd_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  int nChecks = 0;
  int nFails  = 0;

  fifo_sync_fwft dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .clr_err      (clr_err),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given request inputs; returns 1 time unit after the edge.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re,
                       input logic fl, input logic ce);
    wr_en = we; wr_data = wd; rd_en = re; flush = fl; clr_err = ce;
    @(posedge clock);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkEq({tag, ".empty"}, empty, 1);
    checkEq({tag, ".full"}, full, 0);
    checkEq({tag, ".ae"}, almost_empty, 1);
    checkEq({tag, ".af"}, almost_full, 0);
    checkEq({tag, ".count"}, count, 0);
    checkEq({tag, ".ovf"}, overflow, 0);
    checkEq({tag, ".udf"}, underflow, 0);
    checkEq({tag, ".rd_data"}, rd_data, 0);
  endtask

  logic [7:0] q[$];

  initial begin
    reset_n = 1'b0; flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #1;
    checkResetState("reset");
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // 1: FWFT latency and ordering
    cycle(1, 8'h11, 0, 0, 0);
    checkEq("t1.head_after_first", rd_data, 8'h11);
    checkEq("t1.empty_after_first", empty, 0);
    cycle(1, 8'h22, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 0);
    checkEq("t1.count3", count, 3);
    checkEq("t1.head_still", rd_data, 8'h11);
    cycle(0, 0, 1, 0, 0);
    checkEq("t1.pop1", rd_data, 8'h22);
    cycle(0, 0, 1, 0, 0);
    checkEq("t1.pop2", rd_data, 8'h33);
    cycle(0, 0, 1, 0, 0);
    checkEq("t1.empty_end", empty, 1);
    checkEq("t1.rd_data_zero", rd_data, 0);

    // 2: fill to full, flag thresholds, overflow
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 8'h40 + 8'(i - 1), 0, 0, 0);
      if (i == 2)  checkEq("t2.ae_at2", almost_empty, 1);
      if (i == 3)  checkEq("t2.ae_at3", almost_empty, 0);
      if (i == 11) checkEq("t2.af_at11", almost_full, 0);
      if (i == 12) checkEq("t2.af_at12", almost_full, 1);
      if (i == 15) checkEq("t2.full_at15", full, 0);
    end
    checkEq("t2.full", full, 1);
    checkEq("t2.count16", count, 16);
    cycle(1, 8'hFF, 0, 0, 0);
    checkEq("t2.overflow", overflow, 1);
    checkEq("t2.count_held", count, 16);
    checkEq("t2.head_unchanged", rd_data, 8'h40);

    // 3: write while full with concurrent read
    cycle(1, 8'hAA, 1, 0, 0);
    checkEq("t3.count16", count, 16);
    checkEq("t3.head", rd_data, 8'h41);
    for (int i = 0; i < 15; i++) begin
      checkEq("t3.drain", rd_data, 8'h41 + 8'(i));
      cycle(0, 0, 1, 0, 0);
    end
    checkEq("t3.aa_head", rd_data, 8'hAA);
    checkEq("t3.count1", count, 1);
    cycle(0, 0, 1, 0, 0);
    checkEq("t3.empty", empty, 1);
    checkEq("t3.ovf_sticky", overflow, 1);
    cycle(0, 0, 0, 0, 1);
    checkEq("t3.ovf_cleared", overflow, 0);

    // 4: read when empty is rejected, no bypass
    cycle(1, 8'h5A, 1, 0, 0);
    checkEq("t4.count1", count, 1);
    checkEq("t4.underflow", underflow, 1);
    checkEq("t4.head", rd_data, 8'h5A);
    cycle(0, 0, 0, 0, 1);
    checkEq("t4.udf_cleared", underflow, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 1);
    checkEq("t4.set_beats_clear", underflow, 1);
    cycle(0, 0, 0, 0, 1);
    checkEq("t4.udf_cleared2", underflow, 0);

    // 5: 20 writes / 20 reads crossing the pointer wrap
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'h80 + 8'(i), 0, 0, 0);
      q.push_back(8'h80 + 8'(i));
    end
    for (int i = 4; i < 20; i++) begin
      checkEq("t5.head_mid", rd_data, q[0]);
      void'(q.pop_front());
      cycle(1, 8'h80 + 8'(i), 1, 0, 0);
      q.push_back(8'h80 + 8'(i));
    end
    checkEq("t5.count4", count, 4);
    while (q.size() > 0) begin
      checkEq("t5.head_tail", rd_data, q[0]);
      void'(q.pop_front());
      cycle(0, 0, 1, 0, 0);
    end
    checkEq("t5.empty", empty, 1);
    checkEq("t5.no_ovf", overflow, 0);
    checkEq("t5.no_udf", underflow, 0);

    // 6: flush, then async reset mid-burst
    for (int i = 0; i < 5; i++) cycle(1, 8'h60 + 8'(i), 0, 0, 0);
    checkEq("t6.count5", count, 5);
    cycle(1, 8'hEE, 0, 1, 0);
    checkEq("t6.flush_count", count, 0);
    checkEq("t6.flush_empty", empty, 1);
    checkEq("t6.flush_ovf", overflow, 0);
    cycle(0, 0, 1, 1, 0);
    checkEq("t6.flush_no_udf", underflow, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'h70 + 8'(i), 0, 0, 0);
    checkEq("t6.pre_reset_head", rd_data, 8'h70);
    wr_en = 1'b1; wr_data = 8'h99;
    #2 reset_n = 1'b0;
    #1;
    checkResetState("t6.async");
    wr_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1, 8'h77, 0, 0, 0);
    checkEq("t6.fresh_head", rd_data, 8'h77);
    checkEq("t6.fresh_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
